// File: rtl/can_frame_tail_tx.sv
// CAN frame tail generator: CRC delimiter, ACK slot, ACK delimiter, EOF and
// intermission, advancing one bit per SP edge. Every output is registered on SP.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for start; TX recessive
// S_CRC_DEL  | CRC delimiter bit, F_CRC_D high
// S_ACK_SLOT | ACK slot; dominant only when acting as receiver with good CRC
// S_ACK_DEL  | ACK delimiter bit, F_ACK_D high
// S_EOF      | EOF_LEN recessive end-of-frame bits
// S_IFS      | IFS_LEN intermission bits; dominant RX ends it early
module can_frame_tail_tx #(
    parameter int EOF_LEN = 7,
    parameter int IFS_LEN = 3,
    parameter int CNT_W   = 4
) (
    input  logic SP,
    input  logic reset,
    input  logic start,
    input  logic role_tx,
    input  logic crc_ok,
    input  logic RX,
    input  logic FORM_Error,
    output logic TX,
    output logic F_CRC_D,
    output logic F_ACK_D,
    output logic ACK_Error,
    output logic overload_req,
    output logic sof_det,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRC_DEL,
        S_ACK_SLOT,
        S_ACK_DEL,
        S_EOF,
        S_IFS
    } state_t;

    localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_LEN - 1);
    localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             role_q, role_d;
    logic             crc_q, crc_d;
    logic             tx_d, f_crc_d_d, f_ack_d_d, ack_err_d;
    logic             overload_d, sof_d, busy_d, done_d;

    // State, bit counter, latched frame attributes and registered outputs.
    always_ff @(posedge SP or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            role_q       <= 1'b0;
            crc_q        <= 1'b0;
            TX           <= 1'b1;
            F_CRC_D      <= 1'b0;
            F_ACK_D      <= 1'b0;
            ACK_Error    <= 1'b0;
            overload_req <= 1'b0;
            sof_det      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            role_q       <= role_d;
            crc_q        <= crc_d;
            TX           <= tx_d;
            F_CRC_D      <= f_crc_d_d;
            F_ACK_D      <= f_ack_d_d;
            ACK_Error    <= ack_err_d;
            overload_req <= overload_d;
            sof_det      <= sof_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    // Next-state logic; the bus-facing outputs are derived from the state being
    // entered so they line up with the bit that state represents.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        role_d     = role_q;
        crc_d      = crc_q;
        ack_err_d  = ACK_Error;
        overload_d = 1'b0;
        sof_d      = 1'b0;
        done_d     = 1'b0;

        if (state_q == S_IDLE) begin
            // An abort request arriving with start cancels the frame before it begins.
            if (start && !FORM_Error) begin
                state_d   = S_CRC_DEL;
                cnt_d     = '0;
                role_d    = role_tx;
                crc_d     = crc_ok;
                ack_err_d = 1'b0;
            end
        end else if (FORM_Error) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_CRC_DEL: begin
                    state_d = S_ACK_SLOT;
                    cnt_d   = '0;
                end
                S_ACK_SLOT: begin
                    state_d = S_ACK_DEL;
                    cnt_d   = '0;
                    if (role_q && RX) ack_err_d = 1'b1;
                end
                S_ACK_DEL: begin
                    state_d = S_EOF;
                    cnt_d   = '0;
                end
                S_EOF: begin
                    if (cnt_q == EOF_LAST) begin
                        state_d = S_IFS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_IFS: begin
                    if (!RX) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        if (cnt_q == IFS_LAST) sof_d = 1'b1;
                        else                   overload_d = 1'b1;
                    end else if (cnt_q == IFS_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        tx_d      = !((state_d == S_ACK_SLOT) && !role_d && crc_d);
        f_crc_d_d = (state_d == S_CRC_DEL);
        f_ack_d_d = (state_d == S_ACK_DEL);
        busy_d    = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_can_frame_tail_tx.sv
// Bench for can_frame_tail_tx: directed and random frames checked against a
// bit-position model of the frame tail.
module tb_can_frame_tail_tx;

    localparam int EOF_LEN = 7;
    localparam int IFS_LEN = 3;
    localparam int NORM_END = 3 + EOF_LEN + IFS_LEN;  // edge that returns to idle

    logic SP = 1'b0;
    logic reset, start, role_tx, crc_ok, RX, FORM_Error;
    logic TX, F_CRC_D, F_ACK_D, ACK_Error, overload_req, sof_det, busy, done;

    int vectors = 0;
    int errors  = 0;

    can_frame_tail_tx #(.EOF_LEN(EOF_LEN), .IFS_LEN(IFS_LEN), .CNT_W(4)) dut (
        .SP(SP), .reset(reset), .start(start), .role_tx(role_tx), .crc_ok(crc_ok),
        .RX(RX), .FORM_Error(FORM_Error), .TX(TX), .F_CRC_D(F_CRC_D), .F_ACK_D(F_ACK_D),
        .ACK_Error(ACK_Error), .overload_req(overload_req), .sof_det(sof_det),
        .busy(busy), .done(done)
    );

    always #5 SP = ~SP;

    // {TX, F_CRC_D, F_ACK_D, ACK_Error, overload_req, sof_det, busy, done}
    wire [7:0] obs = {TX, F_CRC_D, F_ACK_D, ACK_Error, overload_req, sof_det, busy, done};

    task automatic check(input string tag, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SP);
        #1;
    endtask

    // One frame. Edge 0 accepts start; after edge n the frame is at tail bit n
    // (0 = CRC delimiter, 1 = ACK slot, 2 = ACK delimiter, 3.. EOF, then IFS).
    // form_at: edge at which FORM_Error is high (-1 none).
    // dom_at : intermission bit index at which RX is dominant (-1 none).
    task automatic run_frame(input string name, input bit role, input bit crc,
                             input bit ack_rx, input int form_at, input int dom_at);
        int  fin;
        int  why;  // 0 normal, 1 form abort, 2 dominant in intermission
        bit  ack_set;
        logic [7:0] exp;
        fin = NORM_END;
        why = 0;
        if (dom_at >= 0) begin
            fin = 3 + EOF_LEN + 1 + dom_at;
            why = 2;
        end
        if (form_at >= 1 && form_at <= fin) begin
            fin = form_at;
            why = 1;
        end
        ack_set = role && ack_rx && !(form_at >= 1 && form_at <= 2);

        start = 1'b1; role_tx = role; crc_ok = crc; RX = 1'b1; FORM_Error = 1'b0;
        step();
        for (int n = 0; n <= fin + 1; n++) begin
            bit b;
            b = (n < fin);
            exp[7] = !(b && n == 1 && !role && crc);
            exp[6] = b && n == 0;
            exp[5] = b && n == 2;
            exp[4] = ack_set && n >= 2;
            exp[3] = (n == fin) && why == 2 && dom_at < IFS_LEN - 1;
            exp[2] = (n == fin) && why == 2 && dom_at == IFS_LEN - 1;
            exp[1] = b;
            exp[0] = (n == fin) && why == 0;
            check($sformatf("%s bit%0d", name, n), exp);
            if (n <= fin) begin
                RX         = (n + 1 == 2) ? ack_rx :
                             (dom_at >= 0 && n + 1 == 3 + EOF_LEN + 1 + dom_at) ? 1'b0 : 1'b1;
                FORM_Error = (n + 1 == form_at);
                start      = (n + 1 <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
                role_tx    = 1'($urandom_range(0, 1));
                crc_ok     = 1'($urandom_range(0, 1));
                step();
            end
        end
        start = 1'b0; FORM_Error = 1'b0; RX = 1'b1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; role_tx = 1'b0; crc_ok = 1'b0; RX = 1'b1; FORM_Error = 1'b0;
        #12;
        check("reset_state", 8'b1000_0000);
        reset = 1'b1;
        step();
        check("idle_after_reset", 8'b1000_0000);

        // start together with FORM_Error in idle is refused
        start = 1'b1; FORM_Error = 1'b1;
        step();
        start = 1'b0; FORM_Error = 1'b0;
        check("start_with_form", 8'b1000_0000);
        step();
        check("start_with_form_2", 8'b1000_0000);

        run_frame("tx_acked",      1'b1, 1'b0, 1'b0, -1, -1);
        run_frame("tx_no_ack",     1'b1, 1'b1, 1'b1, -1, -1);
        run_frame("tx_acked_clr",  1'b1, 1'b1, 1'b0, -1, -1);
        run_frame("rx_crc_good",   1'b0, 1'b1, 1'b1, -1, -1);
        run_frame("rx_crc_bad",    1'b0, 1'b0, 1'b1, -1, -1);
        run_frame("form_eof4",     1'b1, 1'b0, 1'b1, 7, -1);
        run_frame("form_ackslot",  1'b1, 1'b0, 1'b1, 2, -1);
        run_frame("ifs_ovl_bit1",  1'b0, 1'b1, 1'b1, -1, 0);
        run_frame("ifs_ovl_bit2",  1'b1, 1'b0, 1'b0, -1, 1);
        run_frame("ifs_sof_bit3",  1'b1, 1'b0, 1'b0, -1, 2);
        run_frame("form_vs_done",  1'b0, 1'b1, 1'b1, NORM_END, -1);
        run_frame("form_vs_sof",   1'b0, 1'b1, 1'b1, NORM_END, 2);

        // Asynchronous reset in the middle of the ACK delimiter
        start = 1'b1; role_tx = 1'b1; crc_ok = 1'b0; RX = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_reset_ack_del", 8'b1011_0010);
        #2 reset = 1'b0;
        #1 check("async_reset_mid", 8'b1000_0000);
        #2 reset = 1'b1;
        step();
        check("idle_after_mid_reset", 8'b1000_0000);

        for (int k = 0; k < 40; k++) begin
            int f, d;
            f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NORM_END)) : -1;
            d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, IFS_LEN - 1)) : -1;
            run_frame($sformatf("rand%0d", k), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f, d);
            if ($urandom_range(0, 1) == 1) begin
                step();
                vectors++;
                assert (busy === 1'b0 && TX === 1'b1 && done === 1'b0) else begin
                    errors++;
                    $error("FAIL rand%0d_idle_gap: observed %b expected busy=0 TX=1 done=0", k, obs);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
